sbox_sched: RTL

SBOX_SCHED -- requirements
Module: sbox_sched

---
 rtl/sbox_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sbox_sched.sv
// Shared 4-lane AES forward S-box scheduler: arbitrates a 128-bit state SubBytes
// port and a 32-bit key-schedule SubWord port onto one 32-bit substitution bank.
module sbox_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_req,
  input  logic [127:0] s_data,
  output logic         s_ack,
  output logic         s_valid,
  output logic [127:0] s_result,
  input  logic         k_req,
  input  logic [31:0]  k_data,
  output logic         k_ack,
  output logic         k_valid,
  output logic [31:0]  k_result,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SUB_S, SUB_K} state_t;

  state_t       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic         last_k_q, last_k_d;
  logic [127:0] op_q, op_d;
  logic [95:0]  acc_q, acc_d;
  logic [127:0] s_result_q, s_result_d;
  logic [31:0]  k_result_q, k_result_d;
  logic         s_ack_q, s_ack_d, k_ack_q, k_ack_d;
  logic         s_valid_q, s_valid_d, k_valid_q, k_valid_d;
  logic [31:0]  lane_in, lane_out;
  logic         grant_s, grant_k;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    lane_in = op_q[31:0];
    if (state_q == SUB_S) begin
      case (beat_q)
        2'd1:    lane_in = op_q[63:32];
        2'd2:    lane_in = op_q[95:64];
        2'd3:    lane_in = op_q[127:96];
        default: lane_in = op_q[31:0];
      endcase
    end
    for (int i = 0; i < 4; i++) lane_out[8*i +: 8] = sbox(lane_in[8*i +: 8]);
  end

  // On contention the port that did not win last time goes first.
  assign grant_k = k_req && (!s_req || !last_k_q);
  assign grant_s = s_req && !grant_k;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_k_d   = last_k_q;
    op_d       = op_q;
    acc_d      = acc_q;
    s_result_d = s_result_q;
    k_result_d = k_result_q;
    s_ack_d    = 1'b0;
    k_ack_d    = 1'b0;
    s_valid_d  = 1'b0;
    k_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_k) begin
          op_d     = {96'h0, k_data};
          last_k_d = 1'b1;
          k_ack_d  = 1'b1;
          state_d  = SUB_K;
        end else if (grant_s) begin
          op_d     = s_data;
          last_k_d = 1'b0;
          s_ack_d  = 1'b1;
          beat_d   = 2'd0;
          state_d  = SUB_S;
        end
      end
      SUB_S: begin
        beat_d = beat_q + 2'd1;
        case (beat_q)
          2'd0: acc_d[31:0]  = lane_out;
          2'd1: acc_d[63:32] = lane_out;
          2'd2: acc_d[95:64] = lane_out;
          default: begin
            // Whole state lands at once so no partial result is ever visible.
            s_result_d = {lane_out, acc_q};
            s_valid_d  = 1'b1;
            state_d    = IDLE;
          end
        endcase
      end
      SUB_K: begin
        k_result_d = lane_out;
        k_valid_d  = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      last_k_q   <= 1'b0;
      op_q       <= '0;
      acc_q      <= '0;
      s_result_q <= '0;
      k_result_q <= '0;
      s_ack_q    <= 1'b0;
      k_ack_q    <= 1'b0;
      s_valid_q  <= 1'b0;
      k_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_k_q   <= last_k_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      s_result_q <= s_result_d;
      k_result_q <= k_result_d;
      s_ack_q    <= s_ack_d;
      k_ack_q    <= k_ack_d;
      s_valid_q  <= s_valid_d;
      k_valid_q  <= k_valid_d;
    end
  end

  assign s_ack    = s_ack_q;
  assign k_ack    = k_ack_q;
  assign s_valid  = s_valid_q;
  assign k_valid  = k_valid_q;
  assign s_result = s_result_q;
  assign k_result = k_result_q;
  assign busy     = (state_q != IDLE);

endmodule
